fw_ip_cfg_shift: RTL
====================

// Module: fw_ip_cfg_shift
// PURPOSE
//  Parametrised FW IP that drives the DUT static-config serial chain (fw_config_clk/fw_config_in/fw_config_load).
//  SW loads a TX image word-by-word, issues execute, and the block shifts the whole image MSB-first.
//  While shifting, it captures fw_config_out into an RX image that SW can read back.
//  Sits between common_sw_to_fw_side (op-code decode) and common_fw_to_dut_side, one instance per dev_id.
// PARAMETERS
//  CFG_WORDS  48  number of 16-bit config words, 1..256; CFG_BITS = 16*CFG_WORDS
//  CLK_DIV    4   fw_config_clk half-period in fw_clk cycles, >=1
// PORTS
//  fw_clk                     in   1   FW clock, all logic rising-edge
//  fw_rst                     in   1   synchronous reset, active-high
//  fw_dev_id_enable           in   1   qualifies every op code below; no op-code action when 0
//  fw_op_code_w_reset         in   1   soft reset: same effect as fw_rst, except TX/RX images are kept
//  fw_op_code_w_cfg_array_0   in   1   write TX word: addr = sw_write24_0[23:16], data = [15:0]
//  fw_op_code_r_cfg_array_0   in   1   read TX word at sw_write24_0[23:16]
//  fw_op_code_r_cfg_array_1   in   1   read RX word at sw_write24_0[23:16]
//  fw_op_code_r_status        in   1   read status word into fw_read_data32
//  fw_op_code_w_execute       in   1   start shift; sw_write24_0[0] -> fw_super_pixel_sel
//  sw_write24_0               in   24  SW payload
//  fw_read_data32             out  32  registered read data
//  fw_read_status32           out  32  live status {busy,done,err_busy,err_addr,12'h0,bit_cnt[15:0]}
//  fw_super_pixel_sel         out  1   latched at accepted execute
//  fw_config_clk              out  1   serial clock, idle low
//  fw_config_in               out  1   serial data to DUT
//  fw_config_load             out  1   load strobe after last bit
//  fw_config_out              in   1   serial data from DUT
// BEHAVIOUR
//  Reset (fw_rst): all outputs 0, FSM IDLE, bit_cnt 0, flags 0; TX/RX images cleared to 0. Abort is immediate.
//  Word w maps to bits [16w+15:16w]; image bit CFG_BITS-1 (word CFG_WORDS-1 bit 15) is shifted first.
//  Writes: accepted only in IDLE with addr < CFG_WORDS; TX word updated on the next edge.
//   - while busy: write dropped, err_busy<=1;  addr >= CFG_WORDS: dropped, err_addr<=1 (sticky).
//  Reads: fw_read_data32 <= {16'h0, word} one cycle after the op code; out-of-range addr returns 0 and sets err_addr.
//   - r_status loads fw_read_status32 value; fw_read_data32 holds its value when no read op is present.
//  FSM IDLE -> LO -> HI -> (LO | LOAD) -> IDLE, with div_cnt counting 0..CLK_DIV-1 in each phase.
//   - IDLE: execute accepted -> LO; busy<=1, done<=0, err flags cleared, bit_cnt 0, TX image copied to the shift register.
//   - Also in IDLE: fw_config_in <= shift-register MSB, and RX shift register <= 0.
//   - Execute while busy: ignored, err_busy<=1.
//   - LO, config_clk=0, CLK_DIV cycles -> HI; config_clk<=1, and on the same edge fw_config_out is sampled into RX LSB (shift left).
//   - HI, config_clk=1, CLK_DIV cycles -> config_clk<=0, TX shifts left, fw_config_in <= new MSB, bit_cnt++.
//   - From HI: next LO if bit_cnt+1 < CFG_BITS, else LOAD.
//   - LOAD: config_load=1 for 2*CLK_DIV cycles, config_in=0 -> IDLE; RX shift register copied into the RX image.
//   - On the IDLE entry edge: busy<=0, done<=1.
//  Latency: busy=1 for exactly 2*CLK_DIV*(CFG_BITS+1) fw_clk cycles, starting the cycle after execute.
//  Soft reset mid-shift: FSM IDLE and all serial outputs 0 on the next edge; busy 0; done stays 0.
//   - Soft reset leaves the RX image unchanged from before the shift.
//  Simultaneous op codes: w_reset wins; then execute; a read alongside execute is served normally.
//  fw_read_status32.bit_cnt saturates at 16 bits (CFG_BITS <= 4096 always fits).
// TESTING
//  T1 reset: pulse fw_rst during a shift -> next cycle all outputs 0, status 32'h0, r_cfg_array_0 addr 5 returns 0.
//  T2 loopback: CLK_DIV=4, CFG_WORDS=48, write word k = 16'hA500+k, execute, tie config_out=config_in.
//   -> busy high for 6152 cycles, then done=1 and RX word k == 16'hA500+k for all k.
//   -> first config_clk rise 4 cycles after busy; first bit = 1 (bit15 of 16'hA52F).
//  T3 CLK_DIV=1, CFG_WORDS=1, word 16'h8001, config_out tied 1 -> 34 busy cycles, config_clk toggles every cycle.
//   -> RX word 16'hFFFF; load high 2 cycles.
//  T4 write addr 3 = 16'h1234 while busy -> err_busy=1, TX word 3 unchanged after completion.
//   -> a second execute mid-shift does not restart (bit_cnt monotonic).
//  T5 write/read addr 48 with CFG_WORDS=48 -> err_addr=1, read returns 32'h0; next execute clears err_addr.
//  T6 soft reset at bit_cnt=100 -> serial lines 0 next cycle, busy 0, done 0; a fresh execute completes normally.

Source files
------------

// File: rtl/fw_ip_cfg_shift_if.sv
// SW-side op-code and read-back bus of one config-chain shifter instance.
// The master modport is the op-code decoder; the slave modport is the shifter.
interface fw_ip_cfg_shift_if;
   logic        fw_dev_id_enable;
   logic        fw_op_code_w_reset;
   logic        fw_op_code_w_cfg_array_0;
   logic        fw_op_code_r_cfg_array_0;
   logic        fw_op_code_r_cfg_array_1;
   logic        fw_op_code_r_status;
   logic        fw_op_code_w_execute;
   logic [23:0] sw_write24_0;
   logic [31:0] fw_read_data32;
   logic [31:0] fw_read_status32;
   logic        fw_super_pixel_sel;

   modport master (
      output fw_dev_id_enable, fw_op_code_w_reset, fw_op_code_w_cfg_array_0,
             fw_op_code_r_cfg_array_0, fw_op_code_r_cfg_array_1, fw_op_code_r_status,
             fw_op_code_w_execute, sw_write24_0,
      input  fw_read_data32, fw_read_status32, fw_super_pixel_sel
   );

   modport slave (
      input  fw_dev_id_enable, fw_op_code_w_reset, fw_op_code_w_cfg_array_0,
             fw_op_code_r_cfg_array_0, fw_op_code_r_cfg_array_1, fw_op_code_r_status,
             fw_op_code_w_execute, sw_write24_0,
      output fw_read_data32, fw_read_status32, fw_super_pixel_sel
   );
endinterface

// File: rtl/fw_ip_cfg_shift.sv
// Shifts a SW-loaded TX config image MSB-first into the DUT static-config chain
// and captures the chain's serial output into an RX image for read-back.
module fw_ip_cfg_shift #(
   parameter int CFG_WORDS = 48,
   parameter int CLK_DIV   = 4
) (
   input  logic             fw_clk,
   input  logic             fw_rst,
   fw_ip_cfg_shift_if.slave bus,
   output logic             fw_config_clk,
   output logic             fw_config_in,
   output logic             fw_config_load,
   input  logic             fw_config_out
);
   localparam int CFG_BITS = 16 * CFG_WORDS;
   localparam int DIV_W    = $clog2(2 * CLK_DIV);
   localparam int IDX_W    = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_LOAD} state_t;

   state_t              r_state;
   logic [DIV_W-1:0]    r_divCnt;
   logic [15:0]         r_bitCnt;
   logic                r_busy;
   logic                r_done;
   logic                r_errBusy;
   logic                r_errAddr;
   logic [31:0]         r_readData;
   logic                r_superPixelSel;
   logic                r_cfgClk;
   logic                r_cfgIn;
   logic                r_cfgLoad;
   logic [CFG_BITS-1:0] r_txShift;
   logic [CFG_BITS-1:0] r_rxShift;
   logic [15:0]         r_txImage [CFG_WORDS];
   logic [15:0]         r_rxImage [CFG_WORDS];

   logic [7:0]          w_addr;
   logic [IDX_W-1:0]    w_idx;
   logic                w_addrOk;
   logic                w_softReset;
   logic                w_write;
   logic                w_readTx;
   logic                w_readRx;
   logic                w_readStatus;
   logic                w_execute;
   logic                w_lastBit;
   logic                w_divEnd;
   logic                w_loadEnd;
   logic [31:0]         w_status;

   assign w_addr       = bus.sw_write24_0[23:16];
   assign w_idx        = w_addr[IDX_W-1:0];
   assign w_addrOk     = {24'h0, w_addr} < 32'(CFG_WORDS);
   assign w_softReset  = bus.fw_dev_id_enable & bus.fw_op_code_w_reset;
   assign w_write      = bus.fw_dev_id_enable & bus.fw_op_code_w_cfg_array_0;
   assign w_readTx     = bus.fw_dev_id_enable & bus.fw_op_code_r_cfg_array_0;
   assign w_readRx     = bus.fw_dev_id_enable & bus.fw_op_code_r_cfg_array_1;
   assign w_readStatus = bus.fw_dev_id_enable & bus.fw_op_code_r_status;
   assign w_execute    = bus.fw_dev_id_enable & bus.fw_op_code_w_execute;
   assign w_lastBit    = ({16'h0, r_bitCnt} + 32'd1) >= 32'(CFG_BITS);
   assign w_divEnd     = r_divCnt == DIV_W'(CLK_DIV - 1);
   assign w_loadEnd    = r_divCnt == DIV_W'(2 * CLK_DIV - 1);
   assign w_status     = {r_busy, r_done, r_errBusy, r_errAddr, 12'h0, r_bitCnt};

   assign bus.fw_read_data32     = r_readData;
   assign bus.fw_read_status32   = w_status;
   assign bus.fw_super_pixel_sel = r_superPixelSel;
   assign fw_config_clk          = r_cfgClk;
   assign fw_config_in           = r_cfgIn;
   assign fw_config_load         = r_cfgLoad;

   // Soft reset shares the hard-reset path but keeps both images intact.
   always_ff @(posedge fw_clk) begin
      if (fw_rst || w_softReset) begin
         r_state         <= S_IDLE;
         r_divCnt        <= '0;
         r_bitCnt        <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_errBusy       <= 1'b0;
         r_errAddr       <= 1'b0;
         r_readData      <= '0;
         r_superPixelSel <= 1'b0;
         r_cfgClk        <= 1'b0;
         r_cfgIn         <= 1'b0;
         r_cfgLoad       <= 1'b0;
         r_txShift       <= '0;
         r_rxShift       <= '0;
         if (fw_rst) begin
            for (int w = 0; w < CFG_WORDS; w++) begin
               r_txImage[w] <= '0;
               r_rxImage[w] <= '0;
            end
         end
      end else begin
         if (w_readTx) begin
            r_readData <= w_addrOk ? {16'h0, r_txImage[w_idx]} : 32'h0;
         end else if (w_readRx) begin
            r_readData <= w_addrOk ? {16'h0, r_rxImage[w_idx]} : 32'h0;
         end else if (w_readStatus) begin
            r_readData <= w_status;
         end

         if (r_state != S_IDLE && (w_execute || w_write)) begin
            r_errBusy <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_divCnt  <= '0;
               r_rxShift <= '0;
               r_cfgIn   <= r_txShift[CFG_BITS-1];
               if (w_execute) begin
                  r_state         <= S_LO;
                  r_busy          <= 1'b1;
                  r_done          <= 1'b0;
                  r_errBusy       <= 1'b0;
                  r_errAddr       <= 1'b0;
                  r_bitCnt        <= '0;
                  r_superPixelSel <= bus.sw_write24_0[0];
                  r_cfgIn         <= r_txImage[CFG_WORDS-1][15];
                  for (int w = 0; w < CFG_WORDS; w++) begin
                     r_txShift[16*w +: 16] <= r_txImage[w];
                  end
               end else if (w_write) begin
                  if (w_addrOk) begin
                     r_txImage[w_idx] <= bus.sw_write24_0[15:0];
                  end else begin
                     r_errAddr <= 1'b1;
                  end
               end
            end
            S_LO: begin
               if (w_divEnd) begin
                  r_divCnt  <= '0;
                  r_state   <= S_HI;
                  r_cfgClk  <= 1'b1;
                  r_rxShift <= {r_rxShift[CFG_BITS-2:0], fw_config_out};
               end else begin
                  r_divCnt <= r_divCnt + DIV_W'(1);
               end
            end
            S_HI: begin
               if (w_divEnd) begin
                  r_divCnt  <= '0;
                  r_cfgClk  <= 1'b0;
                  r_txShift <= {r_txShift[CFG_BITS-2:0], 1'b0};
                  r_bitCnt  <= r_bitCnt + 16'd1;
                  if (w_lastBit) begin
                     r_state   <= S_LOAD;
                     r_cfgIn   <= 1'b0;
                     r_cfgLoad <= 1'b1;
                  end else begin
                     r_state <= S_LO;
                     r_cfgIn <= r_txShift[CFG_BITS-2];
                  end
               end else begin
                  r_divCnt <= r_divCnt + DIV_W'(1);
               end
            end
            S_LOAD: begin
               if (w_loadEnd) begin
                  r_divCnt  <= '0;
                  r_state   <= S_IDLE;
                  r_cfgLoad <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  for (int w = 0; w < CFG_WORDS; w++) begin
                     r_rxImage[w] <= r_rxShift[16*w +: 16];
                  end
               end else begin
                  r_divCnt <= r_divCnt + DIV_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A bad read address is flagged even when an execute clears flags on the same edge.
         if ((w_readTx || w_readRx) && !w_addrOk) begin
            r_errAddr <= 1'b1;
         end
      end
   end
endmodule
